// File: rtl/bldc_pkg.sv
// Shared definitions for the six-step BLDC commutator: sector codes, FSM states,
// and the forward gate table / hall decode helpers.
package bldc_pkg;

  localparam logic [2:0] SECTOR_A       = 3'd0;
  localparam logic [2:0] SECTOR_B       = 3'd1;
  localparam logic [2:0] SECTOR_C       = 3'd2;
  localparam logic [2:0] SECTOR_D       = 3'd3;
  localparam logic [2:0] SECTOR_E       = 3'd4;
  localparam logic [2:0] SECTOR_F       = 3'd5;
  localparam logic [2:0] SECTOR_INVALID = 3'd7;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Phase bit order in both fields is {C,B,A}.
  typedef struct packed {
    logic [2:0] gh_sel;
    logic [2:0] gl;
  } gates_t;

  function automatic logic [2:0] hall_decode(input logic [2:0] hall);
    logic [2:0] s;
    case (hall)
      3'b101:  s = SECTOR_A;
      3'b100:  s = SECTOR_B;
      3'b110:  s = SECTOR_C;
      3'b010:  s = SECTOR_D;
      3'b011:  s = SECTOR_E;
      3'b001:  s = SECTOR_F;
      default: s = SECTOR_INVALID;
    endcase
    return s;
  endfunction

  function automatic gates_t gate_table(input logic [2:0] sector);
    gates_t g;
    g = '0;
    case (sector)
      SECTOR_A: begin g.gh_sel = 3'b100; g.gl = 3'b010; end
      SECTOR_B: begin g.gh_sel = 3'b001; g.gl = 3'b010; end
      SECTOR_C: begin g.gh_sel = 3'b001; g.gl = 3'b100; end
      SECTOR_D: begin g.gh_sel = 3'b010; g.gl = 3'b100; end
      SECTOR_E: begin g.gh_sel = 3'b010; g.gl = 3'b001; end
      SECTOR_F: begin g.gh_sel = 3'b100; g.gl = 3'b001; end
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchroniser followed by a stability counter; a word is accepted
// only after it has been seen unchanged for FILTER_CYCLES consecutive cycles.
module hall_filter #(
  parameter int FILTER_CYCLES = 1000,
  parameter int W             = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] word,
  output logic         valid
);

  localparam int            CW      = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // A fresh word has already been stable for one cycle when first compared.
  always_comb begin
    cnt_next = cnt;
    if (sync2 != cand) begin
      cnt_next = CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      word  <= '0;
      valid <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= cnt_next;
      if (cnt_next == CNT_MAX) begin
        word  <= sync2;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation: filtered hall decode, dead-time FSM driving the
// half-bridge gates, fault shutdown and stall detection.
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int DEADTIME_CYCLES    = 1024,
  parameter int HALL_FILTER_CYCLES = 1000,
  parameter int STALL_CYCLES       = 1_600_000,
  parameter int CNT_W              = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall,
  input  logic       pwm_in,
  input  logic       dir,
  input  logic       enable,
  input  logic       fault_n,
  output logic [2:0] gh,
  output logic [2:0] gl,
  output logic [2:0] sector,
  output logic       sector_step,
  output logic       hall_fault,
  output logic       stall
);

  localparam int               DW        = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DW-1:0]    DEAD_LAST = DW'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

  logic [2:0]       hall_word;
  logic             hall_valid;
  logic [2:0]       sector_dec;
  logic             fault_s1;
  logic             fault_s2;
  logic [CNT_W-1:0] stall_cnt;

  state_t           state, state_next;
  logic [DW-1:0]    dead_cnt, dead_next;
  logic [2:0]       gh_sel, gh_sel_next;
  logic [2:0]       gl_next;
  logic             drive_dir, drive_dir_next;
  logic             fault_cond;
  gates_t           fwd;
  gates_t           pattern;

  hall_filter #(
    .FILTER_CYCLES(HALL_FILTER_CYCLES),
    .W            (3)
  ) u_hall_filter (
    .clk  (clk),
    .reset(reset),
    .din  (hall),
    .word (hall_word),
    .valid(hall_valid)
  );

  assign sector_dec = hall_valid ? hall_decode(hall_word) : SECTOR_INVALID;

  // Steps are only reported between two valid sectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      sector      <= SECTOR_INVALID;
      sector_step <= 1'b0;
      hall_fault  <= 1'b0;
      fault_s1    <= 1'b1;
      fault_s2    <= 1'b1;
    end else begin
      sector      <= sector_dec;
      sector_step <= (sector != SECTOR_INVALID) && (sector_dec != SECTOR_INVALID) &&
                     (sector_dec != sector);
      hall_fault  <= hall_valid && (sector_dec == SECTOR_INVALID);
      fault_s1    <= fault_n;
      fault_s2    <= fault_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!enable || sector_step) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall = (stall_cnt == STALL_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_OFF;
      dead_cnt  <= '0;
      gh_sel    <= '0;
      gl        <= '0;
      drive_dir <= 1'b1;
    end else begin
      state     <= state_next;
      dead_cnt  <= dead_next;
      gh_sel    <= gh_sel_next;
      gl        <= gl_next;
      drive_dir <= drive_dir_next;
    end
  end

  assign fault_cond = !fault_s2 || hall_fault;
  assign fwd        = gate_table(sector);
  // Reverse rotation drives the same phase pair with high and low exchanged.
  assign pattern    = dir ? fwd : '{gh_sel: fwd.gl, gl: fwd.gh_sel};

  always_comb begin
    state_next     = state;
    dead_next      = dead_cnt;
    gh_sel_next    = gh_sel;
    gl_next        = gl;
    drive_dir_next = drive_dir;
    if (fault_cond) begin
      state_next  = ST_FAULT;
      dead_next   = '0;
      gh_sel_next = '0;
      gl_next     = '0;
    end else begin
      case (state)
        ST_OFF: begin
          gh_sel_next = '0;
          gl_next     = '0;
          if (enable && (sector != SECTOR_INVALID)) begin
            state_next = ST_DEAD;
            dead_next  = '0;
          end
        end
        ST_DEAD: begin
          gh_sel_next = '0;
          gl_next     = '0;
          if (!enable) begin
            state_next = ST_OFF;
          end else if (sector_step) begin
            dead_next = '0;
          end else if (dead_cnt == DEAD_LAST) begin
            state_next     = ST_DRIVE;
            gh_sel_next    = pattern.gh_sel;
            gl_next        = pattern.gl;
            drive_dir_next = dir;
          end else begin
            dead_next = dead_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (!enable) begin
            state_next  = ST_OFF;
            gh_sel_next = '0;
            gl_next     = '0;
          end else if (sector_step || (dir != drive_dir)) begin
            state_next  = ST_DEAD;
            dead_next   = '0;
            gh_sel_next = '0;
            gl_next     = '0;
          end
        end
        ST_FAULT: begin
          state_next  = ST_OFF;
          gh_sel_next = '0;
          gl_next     = '0;
        end
        default: begin
          state_next  = ST_OFF;
          gh_sel_next = '0;
          gl_next     = '0;
        end
      endcase
    end
  end

  assign gh = gh_sel & {3{pwm_in}};

endmodule
